// File: rtl/lmu_measctrl_if.sv
// Patch handshake bundle between lmu_measctrl and the per-patch consumer.
// pchidx selects the patch presented through lmu_measmux.
`ifndef PCHADDR_BW
`define PCHADDR_BW 2
`endif

interface lmu_measctrl_if #(
  parameter int PCHADDR_BW = `PCHADDR_BW
);
  logic                  pch_valid;
  logic                  pch_ready;
  logic [PCHADDR_BW-1:0] pchidx;

  modport master (
    output pch_valid,
    output pchidx,
    input  pch_ready
  );

  modport slave (
    input  pch_valid,
    input  pchidx,
    output pch_ready
  );
endinterface

// File: rtl/lmu_measctrl.sv
// LMU measurement sequencer: snapshots measurement arrays on start and
// walks the masked patches in ascending order under valid/ready.
`ifndef NUM_PCH
`define NUM_PCH 4
`endif
`ifndef PCHADDR_BW
`define PCHADDR_BW 2
`endif
`ifndef NUM_DQ
`define NUM_DQ 8
`endif
`ifndef NUM_AQ
`define NUM_AQ 6
`endif

module lmu_measctrl #(
  parameter int NUM_PCH    = `NUM_PCH,
  parameter int PCHADDR_BW = `PCHADDR_BW,
  parameter int NUM_DQ     = `NUM_DQ,
  parameter int NUM_AQ     = `NUM_AQ
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                meas_start,
  input  logic [NUM_PCH-1:0]  pch_mask,
  input  logic [NUM_DQ-1:0]   dqmeas_array_in,
  input  logic [NUM_AQ-1:0]   aqmeas_array_in,
  input  logic [2*NUM_DQ-1:0] pf_array_in,
  lmu_measctrl_if.master      pch_if,
  output logic [NUM_DQ-1:0]   dqmeas_array_ing,
  output logic [NUM_AQ-1:0]   aqmeas_array_ing,
  output logic [2*NUM_DQ-1:0] pf_array_ing,
  output logic                busy,
  output logic                meas_done,
  output logic                start_err
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_PCH-1:0]    rem_q, rem_d, rem_clr;
  logic [PCHADDR_BW-1:0] idx_q, idx_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [NUM_DQ-1:0]     dq_q, dq_d;
  logic [NUM_AQ-1:0]     aq_q, aq_d;
  logic [2*NUM_DQ-1:0]   pf_q, pf_d;
  logic                  hs;

  // Lowest set bit wins: scan downward so the last hit is the smallest.
  function automatic logic [PCHADDR_BW-1:0] lsb_idx(
    input logic [NUM_PCH-1:0] m
  );
    lsb_idx = '0;
    for (int i = NUM_PCH - 1; i >= 0; i--)
      if (m[i]) lsb_idx = PCHADDR_BW'(i);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      dq_q    <= '0;
      aq_q    <= '0;
      pf_q    <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      dq_q    <= dq_d;
      aq_q    <= aq_d;
      pf_q    <= pf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    dq_d    = dq_q;
    aq_d    = aq_q;
    pf_d    = pf_q;
    hs      = valid_q && pch_if.pch_ready;
    rem_clr = rem_q & ~(NUM_PCH'(1) << idx_q);
    unique case (state_q)
      IDLE: begin
        if (meas_start) begin
          dq_d   = dqmeas_array_in;
          aq_d   = aqmeas_array_in;
          pf_d   = pf_array_in;
          rem_d  = pch_mask;
          busy_d = 1'b1;
          if (|pch_mask) begin
            state_d = ISSUE;
            idx_d   = lsb_idx(pch_mask);
            valid_d = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      ISSUE: begin
        err_d = meas_start;
        if (hs) begin
          rem_d = rem_clr;
          if (|rem_clr) begin
            idx_d = lsb_idx(rem_clr);
          end else begin
            state_d = DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        err_d   = meas_start;
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign pch_if.pch_valid = valid_q;
  assign pch_if.pchidx    = idx_q;
  assign busy             = busy_q;
  assign meas_done        = done_q;
  assign start_err        = err_q;
  assign dqmeas_array_ing = dq_q;
  assign aqmeas_array_ing = aq_q;
  assign pf_array_ing     = pf_q;

endmodule

// File: doc/lmu_measctrl.md
# lmu_measctrl

Sequencer for the LMU measurement mux. On a start pulse it snapshots the global data-qubit, ancilla-qubit and Pauli-frame measurement arrays. It then steps `pchidx` through every patch flagged in a patch mask, presenting one patch at a time to the downstream per-patch consumer under a valid/ready handshake. It sits between the measurement-result source and `lmu_measmux`: it drives `lmu_measmux`'s `pchidx` and `*_ing` inputs, and the consumer reads `lmu_measmux`'s `*_pch` outputs.

## Interface
Parameters:
- `NUM_PCH`, default `` `NUM_PCH ``: number of patches.
- `PCHADDR_BW`, default `` `PCHADDR_BW ``: patch index width; must satisfy 2^PCHADDR_BW >= NUM_PCH.
- `NUM_DQ`, default `` `NUM_DQ ``: total data qubits.
- `NUM_AQ`, default `` `NUM_AQ ``: total ancilla qubits.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `meas_start`  in  1  single-cycle request to begin a sweep.
- `pch_mask`  in  NUM_PCH  patches to process; bit i selects patch i; sampled with `meas_start`.
- `dqmeas_array_in`  in  NUM_DQ  raw data-qubit measurement results.
- `aqmeas_array_in`  in  NUM_AQ  raw ancilla-qubit measurement results.
- `pf_array_in`  in  2*NUM_DQ  Pauli-frame bits.
- `pch_ready`  in  1  consumer accepts the current patch.
- `dqmeas_array_ing`  out  NUM_DQ  snapshot of `dqmeas_array_in`, fed to `lmu_measmux`.
- `aqmeas_array_ing`  out  NUM_AQ  snapshot of `aqmeas_array_in`, fed to `lmu_measmux`.
- `pf_array_ing`  out  2*NUM_DQ  snapshot of `pf_array_in`, fed to `lmu_measmux`.
- `pchidx`  out  PCHADDR_BW  patch currently presented, fed to `lmu_measmux`.
- `pch_valid`  out  1  `pchidx` and the mux outputs are valid.
- `busy`  out  1  sweep in progress.
- `meas_done`  out  1  single-cycle pulse at sweep end.
- `start_err`  out  1  single-cycle pulse when `meas_start` arrives while busy.

## Operation
The controller has three states: IDLE, ISSUE and DONE. All outputs are registered.

IDLE:
- On `meas_start`=1, capture the three arrays into the `*_ing` registers and capture `pch_mask` into the pending-mask register `rem`.
- If `pch_mask` is non-zero: go to ISSUE, with `pchidx` set to the lowest set bit (priority encoder) and `pch_valid`=1.
- If `pch_mask` is zero: go to DONE.
- `busy`=1 from the cycle after the start.

ISSUE:
- `pch_valid`=1. `pchidx` is held stable until the handshake (`pch_valid`&&`pch_ready`).
- On the handshake, clear bit `pchidx` in `rem`.
- If further bits remain in `rem`: `pchidx` becomes the lowest remaining set bit and `pch_valid` stays 1. Issue is back-to-back, with no bubble.
- Otherwise: go to DONE and set `pch_valid`=0.

DONE:
- `meas_done`=1 and `busy`=1 for exactly one cycle.
- Next state is IDLE.

Other rules:
- `*_ing` registers only change on an accepted `meas_start` in IDLE. They are held through the whole sweep and after it.
- `meas_start` in ISSUE or DONE is ignored: no state change and no re-capture. It pulses `start_err` the following cycle.
- `pch_mask` bits at indices >= NUM_PCH do not exist. `pchidx` never exceeds NUM_PCH-1.
- Out-of-order patches are never issued: patches are presented in strictly ascending index.

## Timing
- Reset values: `pchidx`=0, `pch_valid`=0, `busy`=0, `meas_done`=0, `start_err`=0, all `*_ing`=0, `rem`=0, state IDLE.
- `rst` asserted in any state aborts the sweep. The next cycle shows reset values, and no `meas_done` is generated.
- Latency: `meas_start` at cycle t → `pch_valid`=1 and first `pchidx` at t+1.
- Handshake at cycle h → next patch at h+1, or `meas_done` at h+1 if none remain.
- Empty mask: `meas_start` at t → `meas_done` at t+1 → `busy`=0 at t+2.
- Full sweep with `pch_ready` tied high and k set bits: valid for k cycles, starting at t+1; `meas_done` at t+k+1; idle at t+k+2. The earliest new start is accepted at t+k+2.
- `meas_start` during the DONE cycle is rejected and flagged with `start_err`.

## Test plan
- NUM_PCH=4, mask 4'b1111, ready=1, start at t → `pchidx` 0,1,2,3 at t+1..t+4 with valid=1; `meas_done` at t+5; busy=0 at t+6.
- Mask 4'b1010, ready low for 3 cycles on each patch → `pchidx`=1 is held for 4 cycles, then `pchidx`=3 is held for 4 cycles. Patches 0 and 2 are never presented, and `*_ing` stays constant.
- Mask 4'b0000 → no valid; `meas_done` at t+1.
- Start with `dqmeas_array_in`=A, then change the inputs to B during the sweep → `dqmeas_array_ing` remains A until the next accepted start.
- `meas_start` during ISSUE → `start_err` pulses one cycle later, and the sweep order and snapshot are unchanged.
- `rst` at the second handshake of a 4-patch sweep → all outputs are 0 the next cycle with no `meas_done`. A new start then sweeps correctly.
